// File: rtl/pc_ctrl.sv
// ID-stage program-counter control: decodes branches/jumps, resolves them in ID,
// and stalls on load-use and branch-operand hazards with a saturating stall counter.
module pc_ctrl #(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned ALU_BR_STALL   = 1,
  parameter int unsigned LOAD_BR_STALL  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] instr_id,
  input  logic [31:0] pc4_id_full,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  output logic [1:0]  pc_src,
  output logic        pc_write,
  output logic [31:0] beq,
  output logic [31:0] jr,
  output logic [27:0] offset28,
  output logic [3:0]  pc_4_id,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic [15:0] stall_cycles
);

  typedef enum logic {RUN, STALL} state_t;

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic [1:0]  need;
  logic        stall;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt;
  logic        is_beq, is_bne, is_j, is_jal, is_jr, is_sw, is_branch;
  logic        uses_rs, uses_rt;
  logic        match_ex, match_mem;

  assign opcode = instr_id[31:26];
  assign funct  = instr_id[5:0];
  assign rs     = instr_id[25:21];
  assign rt     = instr_id[20:16];

  assign is_beq    = (opcode == 6'b000100);
  assign is_bne    = (opcode == 6'b000101);
  assign is_j      = (opcode == 6'b000010);
  assign is_jal    = (opcode == 6'b000011);
  assign is_jr     = (opcode == 6'b000000) && (funct == 6'b001000);
  assign is_sw     = (opcode == 6'b101011);
  assign is_branch = is_beq || is_bne || is_jr;

  assign uses_rs = id_valid;
  assign uses_rt = id_valid && ((opcode == 6'b000000) || is_beq || is_bne || is_sw);

  assign match_ex  = (uses_rs && (rs != 5'd0) && (rs == ex_rd)) ||
                     (uses_rt && (rt != 5'd0) && (rt == ex_rd));
  assign match_mem = (uses_rs && (rs != 5'd0) && (rs == mem_rd)) ||
                     (uses_rt && (rt != 5'd0) && (rt == mem_rd));

  assign beq      = pc4_id_full + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
  assign jr       = rs_data;
  assign offset28 = {instr_id[25:0], 2'b00};
  assign pc_4_id  = pc4_id_full[31:28];

  always_comb begin
    need = 2'd0;
    if (state == RUN && id_valid) begin
      if (is_branch && match_ex && ex_reg_write)
        need = ex_mem_read ? 2'(LOAD_BR_STALL) : 2'(ALU_BR_STALL);
      else if (is_branch && match_mem && mem_mem_read)
        need = 2'd1;
      else if (!is_branch && !is_j && !is_jal && match_ex && ex_mem_read)
        need = 2'(LOAD_USE_STALL);
    end
  end

  assign stall = (state == STALL) || (need != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (need > 2'd1) begin
          state_next = STALL;
          cnt_next   = need - 2'd1;
        end
      end
      STALL: begin
        cnt_next = cnt - 2'd1;
        if (cnt == 2'd1)
          state_next = RUN;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    pc_src       = 2'b00;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (id_valid) begin
      if ((is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data))
        pc_src = 2'b01;
      else if (is_j || is_jal)
        pc_src = 2'b10;
      else if (is_jr)
        pc_src = 2'b11;
      if_id_flush = (pc_src != 2'b00);
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: expectations are queued as stimulus is applied and
// compared mid-cycle against the DUT outputs.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] instr_id, pc4_id_full, rs_data, rt_data;
  logic        ex_reg_write, ex_mem_read, mem_mem_read;
  logic [4:0]  ex_rd, mem_rd;
  logic [1:0]  pc_src;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [31:0] beq, jr;
  logic [27:0] offset28;
  logic [3:0]  pc_4_id;
  logic [15:0] stall_cycles;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_sc;

  typedef struct {
    logic [1:0]  src;
    logic        pw, iw, fl, bub;
    logic [31:0] beq, jr;
    logic [27:0] off;
    logic [3:0]  p4;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pc_ctrl #(.LOAD_USE_STALL(1), .ALU_BR_STALL(1), .LOAD_BR_STALL(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instr_id(instr_id),
    .pc4_id_full(pc4_id_full), .rs_data(rs_data), .rt_data(rt_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .pc_src(pc_src),
    .pc_write(pc_write), .beq(beq), .jr(jr), .offset28(offset28),
    .pc_4_id(pc_4_id), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t datapath();
    exp_t e;
    e.beq = pc4_id_full + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
    e.jr  = rs_data;
    e.off = {instr_id[25:0], 2'b00};
    e.p4  = pc4_id_full[31:28];
    return e;
  endfunction

  task automatic expect_ctl(input logic [1:0] src, input logic stall);
    exp_t e;
    e = datapath();
    e.sc = exp_sc;
    if (stall) begin
      e.src = 2'b00; e.pw = 1'b0; e.iw = 1'b0; e.fl = 1'b0; e.bub = 1'b1;
      if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    end else begin
      e.src = src; e.pw = 1'b1; e.iw = 1'b1; e.fl = (src != 2'b00); e.bub = 1'b0;
    end
    q.push_back(e);
  endtask

  task automatic expect_reset();
    exp_t e;
    e = datapath();
    e.src = 2'b00; e.pw = 1'b0; e.iw = 1'b0; e.fl = 1'b1; e.bub = 1'b1; e.sc = 16'd0;
    exp_sc = 16'd0;
    q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    @(negedge clk);
    if (q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, ".pc_src"},       32'(pc_src),       32'(e.src));
      chk({tag, ".pc_write"},     32'(pc_write),     32'(e.pw));
      chk({tag, ".if_id_write"},  32'(if_id_write),  32'(e.iw));
      chk({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e.fl));
      chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e.bub));
      chk({tag, ".beq"},          beq,               e.beq);
      chk({tag, ".jr"},           jr,                e.jr);
      chk({tag, ".offset28"},     32'(offset28),     32'(e.off));
      chk({tag, ".pc_4_id"},      32'(pc_4_id),      32'(e.p4));
      chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.sc));
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b0; mem_rd = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b1; instr_id = '0; pc4_id_full = '0;
    rs_data = '0; rt_data = '0; exp_sc = '0;
    clear_hazards();

    expect_reset(); check("reset");
    next(); rst_n = 1'b1;

    // beq taken
    instr_id = 32'h1085_0003; rs_data = 32'd5; rt_data = 32'd5; pc4_id_full = 32'h0000_0010;
    expect_ctl(2'b01, 1'b0); check("beq_taken");
    chk("beq_target_const", beq, 32'h0000_001C);
    next();

    // bne with equal operands: not taken
    instr_id = 32'h1485_0003;
    expect_ctl(2'b00, 1'b0); check("bne_not_taken");
    next();

    // beq negative offset wraps
    instr_id = 32'h1085_FFFF; pc4_id_full = 32'h0; rs_data = 32'd1; rt_data = 32'd2;
    expect_ctl(2'b00, 1'b0); check("beq_wrap");
    chk("beq_wrap_const", beq, 32'hFFFF_FFFC);
    next();

    // bne taken
    instr_id = 32'h1485_0001;
    expect_ctl(2'b01, 1'b0); check("bne_taken");
    next();

    // j
    instr_id = 32'h0800_0001; pc4_id_full = 32'hF000_0004;
    expect_ctl(2'b10, 1'b0); check("j");
    chk("j_offset28_const", 32'(offset28), 32'h0000_0004);
    chk("j_pc_4_id_const", 32'(pc_4_id), 32'hF);
    next();

    // jr $8
    instr_id = 32'h0100_0008; rs_data = 32'h0000_0F00;
    expect_ctl(2'b11, 1'b0); check("jr");
    chk("jr_const", jr, 32'h0000_0F00);
    next();

    // invalid instruction: no redirect, no hazard
    id_valid = 1'b0; ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8;
    expect_ctl(2'b00, 1'b0); check("invalid");
    next();
    id_valid = 1'b1; clear_hazards();

    // beq after lw on rs: two stall cycles, second one ignores cleared hazard
    instr_id = 32'h1085_0003; pc4_id_full = 32'h0000_0010; rs_data = 32'd7; rt_data = 32'd7;
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4;
    expect_ctl(2'b00, 1'b1); check("ldbr_stall1");
    next(); clear_hazards();
    expect_ctl(2'b00, 1'b1); check("ldbr_stall2");
    next();
    expect_ctl(2'b01, 1'b0); check("ldbr_resolve");
    chk("ldbr_count", 32'(stall_cycles), 32'd2);
    next();

    // ALU result feeding branch rt: one stall
    ex_reg_write = 1'b1; ex_rd = 5'd5;
    expect_ctl(2'b00, 1'b1); check("alubr_stall");
    next(); clear_hazards();
    expect_ctl(2'b01, 1'b0); check("alubr_resolve");
    next();

    // lw in MEM feeding branch: one stall
    mem_mem_read = 1'b1; mem_rd = 5'd4;
    expect_ctl(2'b00, 1'b1); check("membr_stall");
    next(); clear_hazards();
    expect_ctl(2'b01, 1'b0); check("membr_resolve");
    next();

    // load-use: add $1,$3,$2 after lw $3
    instr_id = 32'h0062_0820; ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
    expect_ctl(2'b00, 1'b1); check("loaduse_stall");
    next(); clear_hazards();
    expect_ctl(2'b00, 1'b0); check("loaduse_after");
    next();

    // $0 never matches
    instr_id = 32'h0002_0820; ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0;
    expect_ctl(2'b00, 1'b0); check("zero_reg");
    next();

    // jal never stalls even with a matching rs field
    instr_id = 32'h0C80_0000; ex_rd = 5'd4;
    expect_ctl(2'b10, 1'b0); check("jal_no_stall");
    next(); clear_hazards();

    // reset asserted while in STALL
    instr_id = 32'h1085_0003; rs_data = 32'd1; rt_data = 32'd1;
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4;
    expect_ctl(2'b00, 1'b1); check("rststall_pre");
    next(); clear_hazards();
    rst_n = 1'b0;
    expect_reset(); check("rststall_reset");
    #1 rst_n = 1'b1;
    next();
    expect_ctl(2'b01, 1'b0); check("rststall_run");
    next();

    // saturation: continuous load-use stalls
    instr_id = 32'h0062_0820; ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
    for (int i = 0; i < 65540; i++) begin
      if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
      next();
    end
    expect_ctl(2'b00, 1'b1); check("sat1");
    chk("sat_const", 32'(stall_cycles), 32'h0000_FFFF);
    next();
    expect_ctl(2'b00, 1'b1); check("sat2");
    next();

    if (q.size() != 0) chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
